// File: rtl/h_drv.sv
// ---------------------------------------------------------------------------
// h_drv : command driver / response checker
//
// The host loads commands into a FIFO. Each command carries the response it
// expects. After i_start, the block issues the commands on a valid/ready
// command port and keeps up to OUT_N of them outstanding. Responses come back
// in issue order. Each one is compared with the oldest outstanding
// expectation and is counted as a pass or a fail. If no response arrives in
// time, the run ends in DONE with a sticky timeout error.
//
// Ports
//   clk, rst            : single clock, synchronous active-high reset
//   i_host_*            : command load (opcode, k, v, expected status/value,
//                         value-compare enable); o_host_rdy = FIFO not full
//   i_start, i_last     : start a run / no further loads will follow
//   o_busy, o_done      : run in progress (RUN/DRAIN) / run finished (DONE)
//   o_cmd_*_w, i_cmd_rdy_w : command issue handshake (valid is combinational)
//   i_rsp_*             : in-order responses
//   o_issued/o_pass/o_fail : saturating 32-bit counters
//   o_err_unexp, o_err_tmo : sticky error flags, cleared by i_start
// ---------------------------------------------------------------------------
package h_pkg;
  typedef logic [3:0]  opcode_t;
  typedef logic [7:0]  k_t;
  typedef logic [15:0] v_t;
  typedef logic [1:0]  status_t;

  typedef struct packed {
    opcode_t opcode;
    k_t      k;
    v_t      v;
    status_t exp_status;
    v_t      exp_v;
    logic    chk_v;
  } cmd_ent_t;

  typedef struct packed {
    status_t exp_status;
    v_t      exp_v;
    logic    chk_v;
  } exp_ent_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

module h_drv #(
  parameter int CMD_N = 8,
  parameter int OUT_N = 4,
  parameter int TMO_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_host_vld,
  input  h_pkg::opcode_t   i_host_opcode,
  input  h_pkg::k_t        i_host_k,
  input  h_pkg::v_t        i_host_v,
  input  h_pkg::status_t   i_host_exp_status,
  input  h_pkg::v_t        i_host_exp_v,
  input  logic             i_host_chk_v,
  output logic             o_host_rdy,
  input  logic             i_start,
  input  logic             i_last,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_cmd_vld_w,
  output h_pkg::opcode_t   o_cmd_opcode_w,
  output h_pkg::k_t        o_cmd_k_w,
  output h_pkg::v_t        o_cmd_v_w,
  input  logic             i_cmd_rdy_w,
  input  logic             i_rsp_vld,
  input  h_pkg::status_t   i_rsp_status,
  input  h_pkg::v_t        i_rsp_v,
  output logic [31:0]      o_issued,
  output logic [31:0]      o_pass,
  output logic [31:0]      o_fail,
  output logic             o_err_unexp,
  output logic             o_err_tmo
);
  import h_pkg::*;

  localparam int CA_W = $clog2(CMD_N);
  localparam int CC_W = CA_W + 1;
  localparam int OA_W = (OUT_N > 1) ? $clog2(OUT_N) : 1;
  localparam int OC_W = $clog2(OUT_N + 1);

  // Expect-FIFO pointer advance; OUT_N need not be a power of two.
  function automatic logic [OA_W-1:0] exp_ptr_inc(input logic [OA_W-1:0] p);
    if (p == OA_W'(OUT_N - 1)) begin
      return {OA_W{1'b0}};
    end else begin
      return p + {{(OA_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_run;

  cmd_ent_t         r_cmd_mem [CMD_N];
  logic [CA_W-1:0]  r_cmd_wr;
  logic [CA_W-1:0]  r_cmd_rd;
  logic [CC_W-1:0]  r_cmd_cnt;
  cmd_ent_t         w_cmd_in;
  cmd_ent_t         w_cmd_head;
  logic             w_cmd_full;
  logic             w_cmd_empty;
  logic             w_load;
  logic             w_issue;

  exp_ent_t         r_exp_mem [OUT_N];
  logic [OA_W-1:0]  r_exp_wr;
  logic [OA_W-1:0]  r_exp_rd;
  logic [OC_W-1:0]  r_out_cnt;
  exp_ent_t         w_exp_in;
  exp_ent_t         w_exp_head;
  logic             w_out_zero;
  logic             w_flush;

  logic             w_rsp_match;
  logic             w_rsp_unexp;
  logic             w_rsp_pass;

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_tmo_hit;

  logic             r_last_seen;
  logic             w_start;

  logic [31:0]      r_issued;
  logic [31:0]      r_pass;
  logic [31:0]      r_fail;
  logic             r_err_unexp;
  logic             r_err_tmo;

  assign w_cmd_full  = (r_cmd_cnt == CC_W'(CMD_N));
  assign w_cmd_empty = (r_cmd_cnt == {CC_W{1'b0}});
  assign o_host_rdy  = !w_cmd_full;
  assign w_load      = i_host_vld && !w_cmd_full;

  assign w_cmd_in    = '{opcode: i_host_opcode, k: i_host_k, v: i_host_v,
                         exp_status: i_host_exp_status, exp_v: i_host_exp_v,
                         chk_v: i_host_chk_v};
  assign w_cmd_head  = r_cmd_mem[r_cmd_rd];

  assign o_cmd_vld_w    = w_run && !w_cmd_empty && (r_out_cnt < OC_W'(OUT_N));
  assign o_cmd_opcode_w = w_cmd_head.opcode;
  assign o_cmd_k_w      = w_cmd_head.k;
  assign o_cmd_v_w      = w_cmd_head.v;
  assign w_issue        = o_cmd_vld_w && i_cmd_rdy_w;

  assign w_exp_in   = '{exp_status: w_cmd_head.exp_status,
                        exp_v: w_cmd_head.exp_v, chk_v: w_cmd_head.chk_v};
  assign w_exp_head = r_exp_mem[r_exp_rd];
  assign w_out_zero = (r_out_cnt == {OC_W{1'b0}});

  // The match uses the registered count, so a command issued this cycle can
  // never be matched by a response in the same cycle.
  assign w_rsp_match = i_rsp_vld && !w_out_zero;
  assign w_rsp_unexp = i_rsp_vld && w_out_zero;
  assign w_rsp_pass  = (i_rsp_status == w_exp_head.exp_status) &&
                       (!w_exp_head.chk_v || (i_rsp_v == w_exp_head.exp_v));

  assign w_tmo_hit = !w_out_zero && !i_rsp_vld && (r_tmo_cnt == {TMO_W{1'b1}});
  assign w_flush   = (r_state == ST_DONE) || w_tmo_hit;
  assign w_start   = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  assign o_issued    = r_issued;
  assign o_pass      = r_pass;
  assign o_fail      = r_fail;
  assign o_err_unexp = r_err_unexp;
  assign o_err_tmo   = r_err_tmo;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; a timeout ends any active run.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_tmo_hit) begin
          w_state_nxt = ST_DONE;
        end else if (r_last_seen && w_cmd_empty) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (w_tmo_hit || w_out_zero) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    w_run  = 1'b0;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_run  = 1'b1;
        o_busy = 1'b1;
      end
      ST_DRAIN: o_busy = 1'b1;
      ST_DONE:  o_done = 1'b1;
      default: begin
        w_run  = 1'b0;
        o_busy = 1'b0;
        o_done = 1'b0;
      end
    endcase
  end

  // Command FIFO storage (contents need no reset; pointers qualify them).
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_cmd_mem[r_cmd_wr] <= w_cmd_in;
    end
  end

  // Command FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_wr  <= {CA_W{1'b0}};
      r_cmd_rd  <= {CA_W{1'b0}};
      r_cmd_cnt <= {CC_W{1'b0}};
    end else begin
      if (w_load) begin
        r_cmd_wr <= r_cmd_wr + {{(CA_W-1){1'b0}}, 1'b1};
      end
      if (w_issue) begin
        r_cmd_rd <= r_cmd_rd + {{(CA_W-1){1'b0}}, 1'b1};
      end
      if (w_load && !w_issue) begin
        r_cmd_cnt <= r_cmd_cnt + {{(CC_W-1){1'b0}}, 1'b1};
      end else if (w_issue && !w_load) begin
        r_cmd_cnt <= r_cmd_cnt - {{(CC_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Expect FIFO storage, written with the head's expectations on issue.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_exp_mem[r_exp_wr] <= w_exp_in;
    end
  end

  // Expect FIFO pointers; the occupancy is the outstanding-command count.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_exp_wr  <= {OA_W{1'b0}};
      r_exp_rd  <= {OA_W{1'b0}};
      r_out_cnt <= {OC_W{1'b0}};
    end else begin
      if (w_issue) begin
        r_exp_wr <= exp_ptr_inc(r_exp_wr);
      end
      if (w_rsp_match) begin
        r_exp_rd <= exp_ptr_inc(r_exp_rd);
      end
      if (w_issue && !w_rsp_match) begin
        r_out_cnt <= r_out_cnt + {{(OC_W-1){1'b0}}, 1'b1};
      end else if (w_rsp_match && !w_issue) begin
        r_out_cnt <= r_out_cnt - {{(OC_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Response timeout: counts cycles without a response while commands are out.
  always_ff @(posedge clk) begin
    if (rst || i_rsp_vld || w_out_zero || w_tmo_hit) begin
      r_tmo_cnt <= {TMO_W{1'b0}};
    end else begin
      r_tmo_cnt <= r_tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
    end
  end

  // last_seen flag; an i_last in the same cycle as i_start wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_seen <= 1'b0;
    end else if (i_last) begin
      r_last_seen <= 1'b1;
    end else if (i_start) begin
      r_last_seen <= 1'b0;
    end
  end

  // Saturating issue/pass/fail counters, cleared when a run starts.
  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_issued <= 32'd0;
      r_pass   <= 32'd0;
      r_fail   <= 32'd0;
    end else begin
      if (w_issue && (r_issued != 32'hFFFF_FFFF)) begin
        r_issued <= r_issued + 32'd1;
      end
      if (w_rsp_match) begin
        if (w_rsp_pass) begin
          if (r_pass != 32'hFFFF_FFFF) begin
            r_pass <= r_pass + 32'd1;
          end
        end else begin
          if (r_fail != 32'hFFFF_FFFF) begin
            r_fail <= r_fail + 32'd1;
          end
        end
      end
    end
  end

  // Sticky error flags, cleared when a run starts.
  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_err_unexp <= 1'b0;
      r_err_tmo   <= 1'b0;
    end else begin
      if (w_rsp_unexp) begin
        r_err_unexp <= 1'b1;
      end
      if (w_tmo_hit) begin
        r_err_tmo <= 1'b1;
      end
    end
  end

endmodule
